// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters, with a one-entry tagged result buffer.
// ALUControl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; optional ALU_ARB_STATS_EN grant counters.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [OP_W-1:0]   r0_op,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [OP_W-1:0]   r1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9);

  typedef enum logic {EMPTY, FULL} buf_state_e;

  buf_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic              gnt0, gnt1, can_accept, accept;
  logic [DATA_W-1:0] sel_a, sel_b, alu_result;
  logic [OP_W-1:0]   sel_op;
  logic [4:0]        shamt;

  // On a conflict the requester that did not win last time gets the ALU.
  always_comb begin
    gnt0       = r0_valid && (!r1_valid || last_grant_q);
    gnt1       = r1_valid && (!r0_valid || !last_grant_q);
    can_accept = (state_q == EMPTY) || rsp_ready;
    r0_ready   = gnt0 && can_accept && !rst;
    r1_ready   = gnt1 && can_accept && !rst;
    accept     = r0_ready || r1_ready;
    sel_a      = gnt1 ? r1_a  : r0_a;
    sel_b      = gnt1 ? r1_b  : r0_b;
    sel_op     = gnt1 ? r1_op : r0_op;
  end

  always_comb begin
    shamt      = sel_b[4:0];
    alu_result = '0;
    case (sel_op)
      OP_ADD:  alu_result = sel_a + sel_b;
      OP_SUB:  alu_result = sel_a - sel_b;
      OP_AND:  alu_result = sel_a & sel_b;
      OP_OR:   alu_result = sel_a | sel_b;
      OP_XOR:  alu_result = sel_a ^ sel_b;
      OP_SLL:  alu_result = sel_a << shamt;
      OP_SRL:  alu_result = sel_a >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(sel_a) >>> shamt);
      OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(sel_a) < $signed(sel_b))};
      OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (sel_a < sel_b)};
      default: alu_result = '0;
    endcase
  end

  // A refill in the same cycle as a drain keeps the buffer FULL.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    if (accept) begin
      state_d      = FULL;
      last_grant_d = r1_ready;
      rsp_id_d     = r1_ready;
      rsp_result_d = alu_result;
      rsp_zero_d   = (alu_result == '0);
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (r0_ready && r0_valid && (cnt0_q != '1)) cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (r1_ready && r1_valid && (cnt1_q != '1)) cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbiter, buffer and ALU.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_op, r1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [1:0]  gnt_cnt0, gnt_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic        m_valid, m_id, m_zero, m_last;
  logic [31:0] m_result;
  logic [1:0]  m_acc;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .OP_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    logic [31:0] fill;
    s = int'(b[4:0]);
    fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: return (a >> s) | fill;
      4'd8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Expected {r1_ready, r0_ready} from the current inputs and model state
  function automatic logic [1:0] model_ready();
    logic winner;
    if (rst || (m_valid && !rsp_ready) || !(r0_valid || r1_valid)) return 2'b00;
    if (r0_valid && r1_valid) winner = ~m_last;
    else winner = r1_valid;
    return winner ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    logic [1:0] rdy;
    rdy = model_ready();
    m_acc = rdy;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_result = 0; m_zero = 0; m_last = 1;
    end else if (rdy != 2'b00) begin
      m_id     = rdy[1];
      m_last   = rdy[1];
      m_result = rdy[1] ? alu_ref(r1_op, r1_a, r1_b) : alu_ref(r0_op, r0_a, r0_b);
      m_zero   = (m_result == 32'd0);
      m_valid  = 1;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin r0_valid = v; r0_op = op; r0_a = a; r0_b = b; end
    else begin r1_valid = v; r1_op = op; r1_a = a; r1_b = b; end
  endtask

  task automatic test_reset();
    rst = 1; rsp_ready = 1;
    set_req(0, 1, 4'd0, 32'd1, 32'd1);
    set_req(1, 1, 4'd0, 32'd2, 32'd2);
    #1;
    n_tests++;
    if ({r1_ready, r0_ready} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 00", {r1_ready, r0_ready}); end
    tick();
    tick();
    rst = 0;
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    #1;
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== 35'd0) begin
      n_fail++; $display("[TB] FAIL reset_state got v=%b id=%b r=%h z=%b want all 0", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
  endtask

  task automatic test_add_basic();
    set_req(0, 1, 4'd0, 32'd5, 32'd7);
    rsp_ready = 1;
    #1;
    n_tests++;
    if (r0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL add_ready got %b want 1", r0_ready); end
    tick();
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
      n_fail++; $display("[TB] FAIL add_rsp got v=%b id=%b r=%0d z=%b want v=1 id=0 r=12 z=0", rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL add_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_alternate();
    logic exp_id;
    exp_id = 1'b1;
    rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1, 4'($urandom_range(0, 9)), $urandom, $urandom);
      set_req(1, 1, 4'($urandom_range(0, 9)), $urandom, $urandom);
      tick();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== m_result) begin
        n_fail++; $display("[TB] FAIL alternate[%0d] got v=%b id=%b r=%h want v=1 id=%b r=%h", i, rsp_valid, rsp_id, rsp_result, exp_id, m_result);
      end
      exp_id = ~exp_id;
    end
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1;
    set_req(1, 1, 4'd1, 32'd9, 32'd9);
    tick();
    rsp_ready = 0;
    set_req(0, 1, 4'd0, 32'd3, 32'd4);
    set_req(1, 1, 4'd4, 32'd6, 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if ({r1_ready, r0_ready} !== 2'b00) begin n_fail++; $display("[TB] FAIL bp_ready[%0d] got %b want 00", i, {r1_ready, r0_ready}); end
      tick();
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
        n_fail++; $display("[TB] FAIL bp_hold[%0d] got v=%b id=%b r=%h z=%b want v=1 id=1 r=0 z=1", i, rsp_valid, rsp_id, rsp_result, rsp_zero);
      end
    end
    rsp_ready = 1;
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
      n_fail++; $display("[TB] FAIL bp_drain got v=%b r=%h z=%b want v=0 r=0 z=1", rsp_valid, rsp_result, rsp_zero);
    end
  endtask

  task automatic test_shift_compare();
    rsp_ready = 1;
    set_req(0, 1, 4'd7, 32'h8000_0000, 32'h21);
    set_req(1, 1, 4'd9, 32'd1, 32'hFFFF_FFFF);
    tick();
    n_tests++;
    if (rsp_id !== 1'b0 || rsp_result !== 32'hC000_0000) begin
      n_fail++; $display("[TB] FAIL sra got id=%b r=%h want id=0 r=c0000000", rsp_id, rsp_result);
    end
    set_req(0, 1, 4'd13, 32'd5, 32'd3);
    tick();
    n_tests++;
    if (rsp_id !== 1'b1 || rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin
      n_fail++; $display("[TB] FAIL sltu got id=%b r=%h z=%b want id=1 r=1 z=0", rsp_id, rsp_result, rsp_zero);
    end
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    tick();
    n_tests++;
    if (rsp_id !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
      n_fail++; $display("[TB] FAIL undef_op got id=%b r=%h z=%b want id=0 r=0 z=1", rsp_id, rsp_result, rsp_zero);
    end
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_reset_midop();
    rsp_ready = 1;
    set_req(0, 1, 4'd0, 32'd1, 32'd2);
    tick();
    rsp_ready = 0;
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1, 4'd0, 32'd4, 32'd4);
    tick();
    rst = 1;
    #1;
    n_tests++;
    if ({r1_ready, r0_ready} !== 2'b00 || rsp_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midrst_ready got rdy=%b v=%b want rdy=00 v=1", {r1_ready, r0_ready}, rsp_valid);
    end
    tick();
    rst = 0;
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_flush got %b want 0", rsp_valid); end
    set_req(0, 1, 4'd1, 32'd10, 32'd3);
    #1;
    n_tests++;
    if ({r1_ready, r0_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL midrst_first got %b want 01", {r1_ready, r0_ready}); end
    tick();
    n_tests++;
    if (rsp_id !== 1'b0 || rsp_result !== 32'd7) begin
      n_fail++; $display("[TB] FAIL midrst_rsp got id=%b r=%h want id=0 r=7", rsp_id, rsp_result);
    end
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 400; i++) begin
      if (!(r0_valid && !m_acc[0] && $urandom_range(0, 9) != 0)) begin
        a = $urandom;
        set_req(0, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), a, ($urandom_range(0, 3) == 0) ? a : $urandom);
      end
      if (!(r1_valid && !m_acc[1] && $urandom_range(0, 9) != 0)) begin
        a = $urandom;
        set_req(1, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), a, ($urandom_range(0, 3) == 0) ? a : $urandom);
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      #1;
      n_tests++;
      if ({r1_ready, r0_ready} !== model_ready()) begin
        n_fail++; $display("[TB] FAIL rand_ready[%0d] got %b want %b", i, {r1_ready, r0_ready}, model_ready());
      end
      tick();
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {m_valid, m_id, m_result, m_zero}) begin
        n_fail++; $display("[TB] FAIL rand_rsp[%0d] got v=%b id=%b r=%h z=%b want v=%b id=%b r=%h z=%b",
                           i, rsp_valid, rsp_id, rsp_result, rsp_zero, m_valid, m_id, m_result, m_zero);
      end
    end
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    rsp_ready = 1;
    tick();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    rst = 1;
    tick();
    rst = 0;
    n_tests++;
    if (gnt_cnt0 !== 2'd0 || gnt_cnt1 !== 2'd0) begin
      n_fail++; $display("[TB] FAIL stats_reset got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1);
    end
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1, 4'd0, 32'(i), 32'd1);
      tick();
    end
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    tick();
    n_tests++;
    if (gnt_cnt0 !== 2'd3 || gnt_cnt1 !== 2'd0) begin
      n_fail++; $display("[TB] FAIL stats_sat got %0d/%0d want 3/0", gnt_cnt0, gnt_cnt1);
    end
  endtask
`endif

  initial begin
    rst = 1; rsp_ready = 0; m_acc = 2'b00;
    m_valid = 0; m_id = 0; m_result = 0; m_zero = 0; m_last = 1;
    set_req(0, 0, 4'd0, 32'd0, 32'd0);
    set_req(1, 0, 4'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    test_reset();
    test_add_basic();
    test_alternate();
    test_backpressure();
    test_shift_compare();
    test_reset_midop();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
